// File: rtl/packer_pkg.sv
// Shared definitions for the class score packer: state encoding, default sizes
// and the slot-offset helper used to address the flat Num bus.
package packer_pkg;

    localparam int DEF_NUM_CLASSES = 10;
    localparam int DEF_SCORE_W     = 26;
    localparam int DEF_IDX_W       = 4;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SETTLE = 2'd1,
        RESULT = 2'd2
    } state_t;

    function automatic int slotOffset(input int slot, input int scoreW);
        return slot * scoreW;
    endfunction

endpackage

// File: rtl/class_score_packer_if.sv
// Score stream, flat Num/Index link to Max, and result handshake of the packer.
// The master side is the packer itself; the slave side is its surroundings.
interface class_score_packer_if
    import packer_pkg::*;
#(
    parameter int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int SCORE_W     = DEF_SCORE_W,
    parameter int IDX_W       = DEF_IDX_W
);

    logic                           in_valid;
    logic                           in_ready;
    logic [SCORE_W-1:0]             in_score;
    logic                           in_last;
    logic [NUM_CLASSES*SCORE_W-1:0] Num;
    logic                           num_valid;
    logic [IDX_W-1:0]               Index;
    logic [IDX_W-1:0]               result_index;
    logic                           result_valid;
    logic                           result_ack;
    logic                           frame_error;

    modport master (
        input  in_valid, in_score, in_last, Index, result_ack,
        output in_ready, Num, num_valid, result_index, result_valid, frame_error
    );

    modport slave (
        output in_valid, in_score, in_last, Index, result_ack,
        input  in_ready, Num, num_valid, result_index, result_valid, frame_error
    );

endinterface

// File: rtl/class_score_packer.sv
// Collects one frame of class scores into the flat Num bus for Max, holds it
// for one settle cycle, then latches Max's Index and offers it downstream.
module class_score_packer
    import packer_pkg::*;
#(
    parameter int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int SCORE_W     = DEF_SCORE_W,
    parameter int IDX_W       = DEF_IDX_W
) (
    input  logic                  clk,
    input  logic                  GlobalReset,
    class_score_packer_if.master  bus
);

    state_t                         r_state;
    logic [IDX_W-1:0]               r_count;
    logic [NUM_CLASSES*SCORE_W-1:0] r_num;
    logic                           r_numValid;
    logic [IDX_W-1:0]               r_resultIndex;
    logic                           r_resultValid;
    logic                           r_frameError;
    logic                           r_errAcc;

    logic w_fill;
    logic w_accept;
    logic w_first;
    logic w_lastSlot;
    logic w_frameEnd;
    logic w_beatErr;

    assign w_fill     = (r_state == FILL);
    assign w_accept   = bus.in_valid && w_fill;
    assign w_first    = (r_count == '0);
    assign w_lastSlot = (r_count == IDX_W'(NUM_CLASSES - 1));
    assign w_frameEnd = w_lastSlot || bus.in_last;
    // A frame is well formed only when in_last lands exactly on the final slot.
    assign w_beatErr  = bus.in_last ^ w_lastSlot;

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            r_state       <= FILL;
            r_count       <= '0;
            r_num         <= '0;
            r_numValid    <= 1'b0;
            r_resultIndex <= '0;
            r_resultValid <= 1'b0;
            r_frameError  <= 1'b0;
            r_errAcc      <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        // First beat wipes stale slots; an early in_last zeroes the unwritten tail.
                        for (int k = 0; k < NUM_CLASSES; k++) begin
                            if (IDX_W'(k) == r_count)
                                r_num[slotOffset(k, SCORE_W) +: SCORE_W] <= bus.in_score;
                            else if (w_first || (bus.in_last && IDX_W'(k) > r_count))
                                r_num[slotOffset(k, SCORE_W) +: SCORE_W] <= '0;
                        end
                        r_errAcc <= (w_first ? 1'b0 : r_errAcc) | w_beatErr;
                        if (w_frameEnd) begin
                            r_state    <= SETTLE;
                            r_numValid <= 1'b1;
                        end else begin
                            r_count <= r_count + 1'b1;
                            if (w_first)
                                r_numValid <= 1'b0;
                        end
                    end
                end
                SETTLE: begin
                    r_resultIndex <= bus.Index;
                    r_frameError  <= r_errAcc;
                    r_resultValid <= 1'b1;
                    r_state       <= RESULT;
                end
                RESULT: begin
                    if (bus.result_ack) begin
                        r_resultValid <= 1'b0;
                        r_count       <= '0;
                        r_state       <= FILL;
                    end
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

    assign bus.in_ready     = w_fill;
    assign bus.Num          = r_num;
    assign bus.num_valid    = r_numValid;
    assign bus.result_index = r_resultIndex;
    assign bus.result_valid = r_resultValid;
    assign bus.frame_error  = r_frameError;

endmodule

// File: tb/tb_class_score_packer.sv
// Directed bench for class_score_packer with a behavioural argmax standing in for Max.
module tb_class_score_packer;
    import packer_pkg::*;

    localparam int NC = DEF_NUM_CLASSES;
    localparam int SW = DEF_SCORE_W;
    localparam int IW = DEF_IDX_W;

    logic clk;
    logic GlobalReset;
    int   checkCount;
    int   passCount;

    class_score_packer_if bus ();

    class_score_packer dut (
        .clk        (clk),
        .GlobalReset(GlobalReset),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for Max: unsigned argmax, lowest index wins ties.
    logic [IW-1:0] maxIdx;
    logic [SW-1:0] maxVal;
    always_comb begin
        maxIdx = '0;
        maxVal = bus.Num[SW-1:0];
        for (int k = 1; k < NC; k++) begin
            if (bus.Num[k*SW +: SW] > maxVal) begin
                maxVal = bus.Num[k*SW +: SW];
                maxIdx = IW'(k);
            end
        end
    end
    assign bus.Index = maxIdx;

    function automatic logic [SW-1:0] slotOf(input int k);
        return bus.Num[slotOffset(k, SW) +: SW];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one beat and waits (bounded) until it is taken.
    task automatic applyStimulus(input logic [SW-1:0] score, input logic last);
        int waitCycles;
        bus.in_valid = 1'b1;
        bus.in_score = score;
        bus.in_last  = last;
        waitCycles   = 0;
        while (!bus.in_ready && waitCycles < 50) begin
            step();
            waitCycles++;
        end
        if (!bus.in_ready) checkOutput("inReadyWait", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic ackResult();
        bus.result_ack = 1'b1;
        step();
        bus.result_ack = 1'b0;
    endtask

    initial begin
        checkCount      = 0;
        passCount       = 0;
        GlobalReset     = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_score    = '0;
        bus.in_last     = 1'b0;
        bus.result_ack  = 1'b0;
        step();
        step();
        GlobalReset = 1'b0;

        checkOutput("rstInReady", 64'(bus.in_ready), 64'd1);
        checkOutput("rstNumValid", 64'(bus.num_valid), 64'd0);
        checkOutput("rstResValid", 64'(bus.result_valid), 64'd0);
        checkOutput("rstResIndex", 64'(bus.result_index), 64'd0);
        checkOutput("rstFrameErr", 64'(bus.frame_error), 64'd0);
        checkOutput("rstNumZero", 64'(|bus.Num), 64'd0);

        // Frame 1: scores 0..9 back to back, in_last on beat 9.
        for (int k = 0; k < NC; k++) applyStimulus(SW'(k), k == NC - 1);
        checkOutput("f1NumValid", 64'(bus.num_valid), 64'd1);
        checkOutput("f1ResValidEarly", 64'(bus.result_valid), 64'd0);
        checkOutput("f1Slot9", 64'(bus.Num[259:234]), 64'd9);
        checkOutput("f1Slot0", 64'(slotOf(0)), 64'd0);
        checkOutput("f1InReadySettle", 64'(bus.in_ready), 64'd0);
        step();
        checkOutput("f1ResValid", 64'(bus.result_valid), 64'd1);
        checkOutput("f1ResIndex", 64'(bus.result_index), 64'd9);
        checkOutput("f1FrameErr", 64'(bus.frame_error), 64'd0);
        ackResult();
        checkOutput("f1AckResValid", 64'(bus.result_valid), 64'd0);
        checkOutput("f1AckInReady", 64'(bus.in_ready), 64'd1);
        checkOutput("f1AckNumValid", 64'(bus.num_valid), 64'd1);

        // Frame 2: same scores with bubbles, result held while ack is low.
        for (int k = 0; k < NC; k++) begin
            applyStimulus(SW'(k), k == NC - 1);
            if (k == 0) checkOutput("f2FirstBeatNumValid", 64'(bus.num_valid), 64'd0);
            if (k != NC - 1) step();
        end
        step();
        for (int c = 0; c < 5; c++) begin
            checkOutput("f2HoldInReady", 64'(bus.in_ready), 64'd0);
            checkOutput("f2HoldResValid", 64'(bus.result_valid), 64'd1);
            checkOutput("f2HoldResIndex", 64'(bus.result_index), 64'd9);
            step();
        end
        ackResult();
        checkOutput("f2AckInReady", 64'(bus.in_ready), 64'd1);

        // Frame 3: short frame 7,3,20,1.
        applyStimulus(26'd7, 1'b0);
        applyStimulus(26'd3, 1'b0);
        applyStimulus(26'd20, 1'b0);
        applyStimulus(26'd1, 1'b1);
        checkOutput("f3Slot2", 64'(slotOf(2)), 64'd20);
        checkOutput("f3Slot4", 64'(slotOf(4)), 64'd0);
        checkOutput("f3Slot9", 64'(slotOf(9)), 64'd0);
        step();
        checkOutput("f3ResIndex", 64'(bus.result_index), 64'd2);
        checkOutput("f3FrameErr", 64'(bus.frame_error), 64'd1);
        ackResult();

        // Frame 4: ten beats without in_last, peak 500 at slot 6.
        for (int k = 0; k < NC; k++) applyStimulus((k == 6) ? 26'd500 : SW'(k * 10), 1'b0);
        checkOutput("f4NumValid", 64'(bus.num_valid), 64'd1);
        step();
        checkOutput("f4ResIndex", 64'(bus.result_index), 64'd6);
        checkOutput("f4FrameErr", 64'(bus.frame_error), 64'd1);
        ackResult();
        for (int k = 0; k < NC; k++) applyStimulus(SW'(k), k == NC - 1);
        step();
        checkOutput("f5FrameErr", 64'(bus.frame_error), 64'd0);
        checkOutput("f5ResIndex", 64'(bus.result_index), 64'd9);
        ackResult();

        // Reset after five beats of a frame discards everything.
        for (int k = 0; k < 5; k++) applyStimulus(SW'(100 + k), 1'b0);
        GlobalReset = 1'b1;
        step();
        GlobalReset = 1'b0;
        checkOutput("midRstNumZero", 64'(|bus.Num), 64'd0);
        checkOutput("midRstNumValid", 64'(bus.num_valid), 64'd0);
        checkOutput("midRstInReady", 64'(bus.in_ready), 64'd1);
        for (int k = 0; k < NC; k++) applyStimulus(SW'(50 - k), k == NC - 1);
        checkOutput("postRstSlot0", 64'(slotOf(0)), 64'd50);
        step();
        checkOutput("postRstResIndex", 64'(bus.result_index), 64'd0);
        checkOutput("postRstFrameErr", 64'(bus.frame_error), 64'd0);

        // Back to back: ack in the first RESULT cycle with the next beat already waiting.
        bus.in_valid   = 1'b1;
        bus.in_score   = 26'd4;
        bus.in_last    = 1'b0;
        bus.result_ack = 1'b1;
        step();
        bus.result_ack = 1'b0;
        checkOutput("b2bResValid", 64'(bus.result_valid), 64'd0);
        checkOutput("b2bInReady", 64'(bus.in_ready), 64'd1);
        checkOutput("b2bNumValidHeld", 64'(bus.num_valid), 64'd1);
        checkOutput("b2bSlot0Held", 64'(slotOf(0)), 64'd50);
        applyStimulus(26'd4, 1'b0);
        checkOutput("b2bFirstBeatNumValid", 64'(bus.num_valid), 64'd0);
        checkOutput("b2bSlot0", 64'(slotOf(0)), 64'd4);
        for (int k = 1; k < NC; k++) applyStimulus((k == 3) ? 26'd900 : SW'(k), k == NC - 1);
        step();
        checkOutput("b2bResIndex", 64'(bus.result_index), 64'd3);
        checkOutput("b2bFrameErr", 64'(bus.frame_error), 64'd0);
        ackResult();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/class_score_packer.md
Name: class_score_packer

Overview:
- Producer side of the Max argmax interface. Collects NUM_CLASSES signed-agnostic 26-bit class scores, one per cycle, over a valid/ready stream.
- Packs the scores into the flat Num bus that Max consumes, then holds that bus stable while Max's combinational Index settles.
- Registers the returned Index and presents it downstream with a valid/ack handshake.
- Sits between the classifier score datapath and the final decision logic.

Parameters:
- NUM_CLASSES, 10, number of scores per frame (slots in Num).
- SCORE_W, 26, bits per score.
- IDX_W, 4, width of the class index; must satisfy 2^IDX_W >= NUM_CLASSES.

Ports:
- clk  input  1  rising-edge clock.
- GlobalReset  input  1  synchronous, active-high reset.
- in_valid  input  1  score beat valid.
- in_ready  output  1  packer can accept a beat.
- in_score  input  SCORE_W  score value.
- in_last  input  1  marks final beat of a frame.
- Num  output  NUM_CLASSES*SCORE_W  packed scores; slot k = Num[k*SCORE_W +: SCORE_W]; connects to Max.Num.
- num_valid  output  1  Num holds a complete frame.
- Index  input  IDX_W  argmax from Max.Index.
- result_index  output  IDX_W  registered winning class.
- result_valid  output  1  result_index valid.
- result_ack  input  1  downstream consumed result.
- frame_error  output  1  frame length mismatch; valid alongside result_valid.

Behaviour:
- Reset (GlobalReset=1 at posedge), all takes effect next cycle: state=FILL, slot counter=0, Num=0, num_valid=0, result_index=0, result_valid=0, frame_error=0, error accumulator=0. Reset mid-frame or mid-result discards all progress.
- in_ready = (state==FILL). A beat is accepted when in_valid && in_ready.
- FILL:
  - An accepted beat writes in_score to slot[count] and increments count.
  - Frame ends on the accepted beat where count==NUM_CLASSES-1 or in_last==1. The first of these wins.
  - Early in_last (count<NUM_CLASSES-1): unwritten slots count+1..NUM_CLASSES-1 are zeroed; error accumulator set.
  - count==NUM_CLASSES-1 without in_last: frame still completes; error accumulator set.
  - On frame end: next state=SETTLE, num_valid=1 from next cycle.
  - No accepted beat: state and registers hold.
- First beat of a frame (count==0):
  - Clears all other slots.
  - Deasserts num_valid.
  - Clears the error accumulator, except for the contribution of the current beat.
- SETTLE:
  - Exactly one cycle; Num is stable and Max's output settles.
  - At the end of the cycle, Index is captured into result_index and the accumulator into frame_error. result_valid=1 from the next cycle. Next state=RESULT.
- RESULT:
  - result_valid, result_index, frame_error and Num are held until result_ack is sampled high.
  - On ack: result_valid=0, count=0, next state=FILL. num_valid stays 1 and Num keeps its contents until the next frame's first beat.
- Latency: last accepted beat at cycle T → num_valid at T+1 → result_valid at T+2.
- result_ack while not in RESULT: ignored.
- in_valid while in SETTLE/RESULT: not accepted (in_ready=0); the beat waits.
- Width: scores are copied bitwise with no arithmetic; count is IDX_W bits and never exceeds NUM_CLASSES-1.

Decomposition:
- Shared package packer_pkg: state encoding (FILL, SETTLE, RESULT), NUM_CLASSES/SCORE_W/IDX_W defaults, slot-offset helper function.
- No sub-module needed. The top-level design instantiates class_score_packer and Max side by side.
- Optional bench-only wrapper: packer_max_top.

Test Plan:
- Scores 0..9 on consecutive cycles, in_last on beat 9 → Num[259:234]=9, num_valid at T+1, result_valid at T+2, result_index=9, frame_error=0.
- Same frame with in_valid bubbles every other cycle; ack held low 5 cycles → in_ready=0 and result stable for all 5 cycles; ack → in_ready=1 next cycle.
- Short frame: scores 7,3,20,1 with in_last on the 4th → slots 4..9 = 0, result_index=2, frame_error=1.
- 10 beats with no in_last, max 500 at slot 6 → frame completes, result_index=6, frame_error=1. Next frame starts cleanly with frame_error=0.
- GlobalReset asserted after 5 beats → next cycle count=0, Num=0, num_valid=0, in_ready=1. A full 10-beat frame after reset gives the correct index.
- Back-to-back frames with ack in the first RESULT cycle → second frame's first beat accepted the cycle after ack; num_valid drops on that beat.
